ps2_scancode_rx: RTL

// - Receives PS/2 keyboard frames on ps2_clk/ps2_data, checks each frame and buffers

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_byte_fifo.sv | 61 ++++++
 rtl/ps2_scancode_rx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared PS/2 frame constants and the frame validity rule.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic       PS2_START_BIT  = 1'b0;
    localparam logic       PS2_STOP_BIT   = 1'b1;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_CODE_W     = 8;

    // Odd parity covers the eight data bits plus the parity bit itself.
    function automatic logic ps2_frame_ok(
        input logic                  start_bit,
        input logic [PS2_CODE_W-1:0] code,
        input logic                  parity_bit,
        input logic                  stop_bit
    );
        return (start_bit == PS2_START_BIT) && (stop_bit == PS2_STOP_BIT) &&
               (^{code, parity_bit} == 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_byte_fifo
//  Brief    : Small FIFO with wrap-bit pointers; simultaneous push/pop always
//             accepted when not empty, including when full.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PS2_CODE_W
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_rptr;
    logic [AW:0]      r_wptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_rptr == r_wptr);
    assign full      = (r_rptr[AW] != r_wptr[AW]) && (r_rptr[AW-1:0] == r_wptr[AW-1:0]);
    assign w_do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the write lands in.
    assign w_do_push = push & (~full | w_do_pop);
    assign drop      = push & full & ~w_do_pop;
    assign dout      = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rptr <= '0;
            r_wptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= din;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scancode_rx
//  Brief    : PS/2 keyboard frame receiver with frame check, mid-frame timeout
//             and scan-code FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  nextdata_n,
    output logic [PS2_CODE_W-1:0] data,
    output logic                  ready,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int                TCNT_W      = $clog2(TIMEOUT_CYC);
    localparam logic [TCNT_W-1:0] C_TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]        C_LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]                r_ps2_clk_sync;
    logic [1:0]                r_ps2_data_sync;
    logic [3:0]                r_bitcnt;
    logic [PS2_FRAME_BITS-2:0] r_buf;
    logic [TCNT_W-1:0]         r_tcnt;
    logic                      r_overflow;
    logic                      r_frame_err;

    logic w_fall;
    logic w_bit;
    logic w_last;
    logic w_frame_ok;
    logic w_push;
    logic w_timeout;
    logic w_empty;
    logic w_full;
    logic w_drop;

    assign w_fall     = r_ps2_clk_sync[2] & ~r_ps2_clk_sync[1];
    assign w_bit      = r_ps2_data_sync[1];
    assign w_last     = w_fall && (r_bitcnt == C_LAST_BIT);
    // The stop bit is checked straight from the synchroniser on the final edge.
    assign w_frame_ok = ps2_frame_ok(r_buf[0], r_buf[8:1], r_buf[9], w_bit);
    assign w_push     = w_last & w_frame_ok;
    assign w_timeout  = !w_fall && (r_bitcnt != 4'd0) && (r_tcnt == C_TCNT_LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ps2_clk_sync  <= 3'b111;
            r_ps2_data_sync <= 2'b11;
        end else begin
            r_ps2_clk_sync  <= {r_ps2_clk_sync[1:0], ps2_clk};
            r_ps2_data_sync <= {r_ps2_data_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bitcnt <= 4'd0;
            r_buf    <= '0;
        end else if (w_fall) begin
            if (w_last) begin
                r_bitcnt <= 4'd0;
            end else begin
                r_buf[r_bitcnt] <= w_bit;
                r_bitcnt        <= r_bitcnt + 4'd1;
            end
        end else if (w_timeout) begin
            r_bitcnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_tcnt <= '0;
        end else if (w_fall || (r_bitcnt == 4'd0) || w_timeout) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= (w_last & ~w_frame_ok) | w_timeout;
            if (w_drop && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ps2_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PS2_CODE_W)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (w_push),
        .din   (r_buf[8:1]),
        .pop   (~nextdata_n),
        .dout  (data),
        .empty (w_empty),
        .full  (w_full),
        .drop  (w_drop)
    );

    assign ready     = ~w_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
